// File: rtl/data_port_arbiter_pkg.sv
// data_port_arbiter_pkg: shared arbiter state and read-owner encodings
package data_port_arbiter_pkg;
  typedef enum logic {ARB, LOCK1} arbStateT;
  typedef enum logic [1:0] {NONE, P0, P1} rdOwnerT;
endpackage

// File: rtl/arb_read_tracker.sv
// arb_read_tracker: remembers who issued last cycle's read and steers RAM read data back to that port
//   issue          owner of the read granted this cycle (NONE for writes/idle)
//   memRdata       RAM read data, valid one cycle after the read was issued
//   rvalid0/1      one-cycle read-valid per port
//   rdata0/1       live RAM data while valid, otherwise the port's last returned word
module arb_read_tracker import data_port_arbiter_pkg::*; #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  rdOwnerT       issue,
  input  logic [DW-1:0] memRdata,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);
  rdOwnerT owner;
  logic [DW-1:0] hold0, hold1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= NONE;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      owner <= issue;
      if (owner == P0) hold0 <= memRdata;
      if (owner == P1) hold1 <= memRdata;
    end
  end
  assign rvalid0 = owner == P0;
  assign rvalid1 = owner == P1;
  assign rdata0 = rvalid0 ? memRdata : hold0;
  assign rdata1 = rvalid1 ? memRdata : hold1;
endmodule

// File: rtl/data_port_arbiter.sv
// data_port_arbiter: shares one RAM data port between a priority CPU port (0) and a DMA port (1)
//   m0_*/m1_*  requester ports: req/we/addr/wdata in, gnt/rvalid/rdata out; m1_lock requests a burst
//   mem_*      RAM data port: we/addr/wdata out, rdata in (one-cycle read latency)
//   busy_lock  port 1 currently owns the RAM through a locked burst
module data_port_arbiter import data_port_arbiter_pkg::*; #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy_lock
);
  localparam logic [3:0] WMAX = 4'(MAX_WAIT);
  localparam logic [7:0] BMAX = 8'(MAX_BURST);
  arbStateT state;
  logic [3:0] waitCnt;
  logic [7:0] burstCnt;
  rdOwnerT issue;
  // port 0 only ever wins in ARB before port 1 has starved; port 1 takes every other requesting cycle
  assign m0_gnt = state == ARB && m0_req && waitCnt < WMAX;
  assign m1_gnt = m1_req && !m0_gnt;
  assign mem_we = m0_gnt ? m0_we : m1_gnt && m1_we;
  assign mem_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
  assign mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
  assign busy_lock = state == LOCK1;
  assign issue = m0_gnt && !m0_we ? P0 : m1_gnt && !m1_we ? P1 : NONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB;
      waitCnt <= '0;
      burstCnt <= '0;
    end else begin
      // in LOCK1 port 1 is never denied, so this also leaves waitCnt at 0 on lock exit
      waitCnt <= m1_req && !m1_gnt ? (waitCnt == WMAX ? WMAX : waitCnt + 4'd1) : '0;
      if (state == ARB) begin
        if (m1_gnt && m1_lock && BMAX > 8'd1) begin
          state <= LOCK1;
          burstCnt <= 8'd1;
        end
      end else begin
        if (m1_gnt) burstCnt <= burstCnt + 8'd1;
        if (!m1_req || !m1_lock || burstCnt + 8'd1 == BMAX) state <= ARB;
      end
    end
  end
  arb_read_tracker #(.DW(DW)) tracker (
    .clk(clk),
    .reset(reset),
    .issue(issue),
    .memRdata(mem_rdata),
    .rvalid0(m0_rvalid),
    .rvalid1(m1_rvalid),
    .rdata0(m0_rdata),
    .rdata1(m1_rdata)
  );
endmodule

// File: tb/tb_data_port_arbiter.sv
// tb_data_port_arbiter: randomized and directed checks of data_port_arbiter against a rule-level model
module tb_data_port_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int MAX_BURST = 8;
  logic clk = 0;
  logic reset = 1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we, busy_lock;
  logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 0;
  logic [15:0] ram [256];
  logic [15:0] shadow [256];
  logic loadEn = 0;
  logic [7:0] loadAddr = 0;
  logic [15:0] loadData = 0;
  int checkCnt = 0, errCnt = 0;
  int starve, burstLen, pend;
  bit locked, known0, known1;
  logic [15:0] pendData, held0, held1;
  logic lastG0 = 0, lastG1 = 0, lastRv0 = 0, lastRv1 = 0, lastBusy = 0;
  logic [15:0] lastRd0 = 0, lastRd1 = 0;

  data_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy_lock(busy_lock)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (loadEn) ram[loadAddr] <= loadData;
    else if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelClear();
    starve = 0;
    burstLen = 0;
    pend = 0;
    locked = 0;
    known0 = 0;
    known1 = 0;
  endtask

  task automatic calc(output bit e0, output bit e1, output bit eWe, output logic [15:0] eAddr, output logic [15:0] eWd);
    e0 = !locked && m0_req && starve < MAX_WAIT;
    e1 = m1_req && !e0;
    eWe = e0 ? m0_we : (e1 && m1_we);
    eAddr = e0 ? m0_addr : e1 ? m1_addr : 16'h0;
    eWd = e0 ? m0_wdata : e1 ? m1_wdata : 16'h0;
  endtask

  task automatic step(input bit rstAtEdge);
    bit e0, e1, eWe;
    logic [15:0] eAddr, eWd;
    #2;
    if (reset) modelClear();
    calc(e0, e1, eWe, eAddr, eWd);
    lastG0 = m0_gnt; lastG1 = m1_gnt; lastRv0 = m0_rvalid; lastRv1 = m1_rvalid;
    lastRd0 = m0_rdata; lastRd1 = m1_rdata; lastBusy = busy_lock;
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("mem_we", mem_we, eWe);
    chk("mem_addr", mem_addr, eAddr);
    chk("mem_wdata", mem_wdata, eWd);
    chk("busy_lock", busy_lock, locked);
    chk("m0_rvalid", m0_rvalid, pend == 1);
    chk("m1_rvalid", m1_rvalid, pend == 2);
    if (pend == 1) chk("m0_rdata", m0_rdata, pendData);
    else if (known0) chk("m0_rdata_hold", m0_rdata, held0);
    if (pend == 2) chk("m1_rdata", m1_rdata, pendData);
    else if (known1) chk("m1_rdata_hold", m1_rdata, held1);
    if (rstAtEdge) begin
      reset = 1;
      modelClear();
      calc(e0, e1, eWe, eAddr, eWd);
    end else if (!reset) begin
      if (pend == 1) begin held0 = pendData; known0 = 1; end
      if (pend == 2) begin held1 = pendData; known1 = 1; end
      pend = (e0 && !m0_we) ? 1 : (e1 && !m1_we) ? 2 : 0;
      pendData = shadow[eAddr[7:0]];
      starve = (m1_req && !e1) ? ((starve < MAX_WAIT) ? starve + 1 : MAX_WAIT) : 0;
      if (!locked) begin
        if (e1 && m1_lock && MAX_BURST > 1) begin locked = 1; burstLen = 1; end
      end else if (!m1_req) locked = 0;
      else begin
        burstLen++;
        if (!m1_lock || burstLen == MAX_BURST) locked = 0;
      end
    end
    if (eWe) shadow[eAddr[7:0]] = eWd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
  endtask

  task automatic doReset();
    idle();
    reset = 1;
    step(0);
    reset = 0;
  endtask

  task automatic setM0(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic setM1(input logic we, input logic [15:0] addr, input logic [15:0] wd, input logic lk);
    m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_lock = lk;
  endtask

  initial begin
    int n1;
    bit r;
    modelClear();
    #1;
    for (int i = 0; i < 256; i++) begin
      loadEn = 1;
      loadAddr = 8'(i);
      loadData = 16'($urandom);
      shadow[i] = loadData;
      @(posedge clk);
      #1;
    end
    loadEn = 0;
    step(0);
    chk("rst_busy", lastBusy, 0);
    chk("rst_rvalid", lastRv0 | lastRv1, 0);
    reset = 0;
    setM0(0, 16'h0030, 16'h0);
    step(1);
    chk("midrd_gnt", lastG0, 1);
    idle();
    step(0);
    chk("midrd_rvalid", lastRv0, 0);
    chk("midrd_busy", lastBusy, 0);
    reset = 0;
    setM0(1, 16'h0010, 16'hBEEF);
    step(0);
    chk("p0_wr_gnt", lastG0, 1);
    setM0(0, 16'h0010, 16'h0);
    step(0);
    chk("p0_rd_gnt", lastG0, 1);
    chk("p0_wr_no_rvalid", lastRv0, 0);
    idle();
    step(0);
    chk("p0_rvalid", lastRv0, 1);
    chk("p0_rdata", lastRd0, 16'hBEEF);
    chk("p0_m1_rvalid", lastRv1, 0);
    doReset();
    setM0(1, 16'h0040, 16'h1234);
    setM1(1, 16'h0041, 16'h5678, 0);
    for (int i = 0; i < 10; i++) begin
      step(0);
      chk("cont_g1", lastG1, i % 5 == 4);
      chk("cont_g0", lastG0, i % 5 != 4);
    end
    doReset();
    setM0(1, 16'h0042, 16'h1111);
    setM1(1, 16'h0043, 16'h2222, 1);
    for (int i = 0; i < 13; i++) begin
      step(0);
      chk("burst_g1", lastG1, i >= 4 && i <= 11);
      chk("burst_g0", lastG0, i < 4 || i == 12);
      chk("burst_busy", lastBusy, i >= 5 && i <= 11);
    end
    doReset();
    setM0(1, 16'h0044, 16'h3333);
    n1 = 0;
    for (int i = 0; i < 9; i++) begin
      setM1(1, 16'h0045, 16'h4444, n1 < 2);
      step(0);
      if (lastG1) n1++;
      chk("unlock_g1", lastG1, i >= 4 && i <= 6);
      chk("unlock_g0", lastG0, i < 4 || i > 6);
    end
    doReset();
    setM0(1, 16'h0020, 16'h1111);
    step(0);
    idle();
    setM1(1, 16'h0021, 16'h2222, 0);
    step(0);
    idle();
    setM0(0, 16'h0020, 16'h0);
    step(0);
    idle();
    setM1(0, 16'h0021, 16'h0, 0);
    step(0);
    chk("il_rv0", lastRv0, 1);
    chk("il_rd0", lastRd0, 16'h1111);
    chk("il_g1", lastG1, 1);
    idle();
    setM0(1, 16'h0022, 16'h5555);
    step(0);
    chk("il_rv1", lastRv1, 1);
    chk("il_rd1", lastRd1, 16'h2222);
    chk("il_rv0_single", lastRv0, 0);
    idle();
    step(0);
    chk("il_wr_no_rvalid", lastRv0 | lastRv1, 0);
    chk("il_rd0_hold", lastRd0, 16'h1111);
    doReset();
    lastG0 = 0;
    lastG1 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!m0_req || lastG0) begin
        m0_req = $urandom_range(0, 9) < 6;
        m0_we = 1'($urandom);
        m0_addr = 16'($urandom_range(0, 255));
        m0_wdata = 16'($urandom);
      end
      if (!m1_req || lastG1) begin
        m1_req = $urandom_range(0, 9) < 8;
        m1_we = 1'($urandom);
        m1_addr = 16'($urandom_range(0, 255));
        m1_wdata = 16'($urandom);
        m1_lock = $urandom_range(0, 3) != 0;
      end
      r = $urandom_range(0, 299) == 0;
      step(r);
      if (reset) begin
        step(0);
        reset = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end
endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Shares the single data port of the main block RAM between two requesters.
- Port 0 is the CPU memory controller (data read/write path). Port 1 is a DMA/blitter engine that streams pixel data.
- Sits between the requesters and the RAM data port. Tracks the 1-cycle synchronous read latency so read data returns to the requester that issued the read.
- Port 0 has priority. A starvation counter and a bounded burst lock guarantee port 1 progress.

Parameters:
- AW, 16, address width
- DW, 16, data width
- MAX_WAIT, 4, cycles port 1 may be denied while requesting before it is forced a grant (1..15)
- MAX_BURST, 8, maximum consecutive locked port-1 grants (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 access request, valid this cycle
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  AW  port 0 address
- m0_wdata  in  DW  port 0 write data
- m0_gnt  out  1  port 0 access accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DW  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata  in  1/1/AW/DW  port 1 request fields, same meaning as port 0
- m1_lock  in  1  port 1 asks to keep ownership after this grant
- m1_gnt, m1_rvalid  out  1  port 1 grant and read-valid
- m1_rdata  out  DW  port 1 read data
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data; valid one cycle after address presented
- busy_lock  out  1  port 1 holds the lock (status/debug)

Behaviour:
- Reset: asynchronous and active-high; clk is the only clock. Reset forces:
  - state=ARB, wait_cnt=0, burst_cnt=0, rd_owner=none;
  - m0_rvalid=0, m1_rvalid=0, busy_lock=0;
  - with no requests present: m0_gnt=m1_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Grants are combinational from the request inputs and the registered state, giving zero-cycle grant latency.
- mem_* is a combinational mux of the granted port. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Exactly one grant at most per cycle. A requester holds req and its fields stable until it sees gnt.
- State ARB:
  - m0_req and wait_cnt<MAX_WAIT: grant port 0.
  - Else m1_req: grant port 1.
  - Both requesting and wait_cnt==MAX_WAIT: grant port 1.
- wait_cnt:
  - increments (saturating at MAX_WAIT) each cycle m1_req=1 and m1_gnt=0;
  - clears on m1_gnt or when m1_req=0.
- ARB -> LOCK1: on an m1_gnt with m1_lock=1; burst_cnt loads 1.
- State LOCK1:
  - port 1 is granted whenever m1_req=1; port 0 is stalled regardless of priority. busy_lock=1.
  - Each m1_gnt increments burst_cnt.
  - Return to ARB after any grant with m1_lock=0, or when burst_cnt reaches MAX_BURST (that grant is the last).
  - Return to ARB on any cycle with m1_req=0; no grant is issued that cycle.
  - On exit, wait_cnt=0.
  - Port 0 starvation is not counted in LOCK1; it is bounded by MAX_BURST.
- Read return:
  - A granted read (we=0) registers rd_owner=port.
  - Next cycle that port's rvalid=1 and its rdata=mem_rdata.
  - The other port's rdata holds its last value; rvalid is high for one cycle only.
  - Back-to-back reads to alternating ports each return correctly: one outstanding read per cycle, in order.
  - A write grant produces no rvalid.
- Simultaneous events: a read grant in the same cycle as the previous read's return is legal; both proceed.
- Reset mid-operation:
  - outstanding rvalid is dropped (no rvalid after reset);
  - the lock is released;
  - counters clear.

Decomposition:
- Shared package: state encoding constants (ARB, LOCK1) and the rd_owner encoding (NONE, P0, P1).
- One sub-module is natural: arb_read_tracker. It holds the registered rd_owner and the rvalid/rdata steering, and is reusable if a third port is added later.

Test Plan:
- Reset asserted mid-read: m0 read granted, reset high next edge -> m0_rvalid stays 0; all counters 0; busy_lock=0.
- Port 0 alone: m0 read addr 0x0010, RAM holds 0xBEEF -> m0_gnt same cycle; m0_rvalid=1 with m0_rdata=0xBEEF next cycle; m1_rvalid=0.
- Contention, MAX_WAIT=4: m0_req and m1_req held continuously -> m0 granted cycles 0-3; m1 granted cycle 4; pattern repeats every 5 cycles.
- Burst lock, MAX_BURST=8: m1_req+m1_lock held with m0_req high -> exactly 8 consecutive m1 grants, busy_lock=1 during them; m0 granted on the 9th cycle.
- Early unlock: lock asserted for grants 1-2, deasserted on grant 3 -> ARB after grant 3; m0 granted next cycle.
- Interleaved reads: m0 read 0x20 (data 0x1111), then m1 read 0x21 (data 0x2222) on the next cycle -> m0_rvalid/0x1111 then m1_rvalid/0x2222 on consecutive cycles; a write grant produces no rvalid.
